// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 7 data bits LSB-first, even parity, 1 or 2 stop bits.
// All outputs are registered from next-state values, so tx_out never glitches.
module uart_tx_frame #(
   parameter int unsigned BAUD_RATE     = 9600,
   parameter int unsigned CLK_PERIOD_NS = 60,
   parameter int unsigned STOP_BITS     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned CLKS_PER_BIT = (1000000000 / BAUD_RATE) / CLK_PERIOD_NS;
   localparam int unsigned CntW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic            StopLast = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [6:0]        shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              tx_out_q, tx_out_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      bit_end  = (baud_q == BaudLast);

      if (state_q != StIdle) begin
         baud_d = bit_end ? '0 : baud_q + CntW'(1);
      end

      case (state_q)
         StIdle: begin
            // ready_q mirrors IDLE, so it alone qualifies the handshake
            if (tx_valid && ready_q) begin
               state_d  = StStart;
               shift_d  = tx_data;
               parity_d = ^tx_data;
               baud_d   = '0;
               bit_d    = '0;
               stop_d   = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'd6) state_d = StParity;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (stop_q == StopLast) state_d = StIdle;
               else                    stop_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      case (state_d)
         StStart:  tx_out_d = 1'b0;
         StData:   tx_out_d = shift_d[0];
         StParity: tx_out_d = parity_d;
         default:  tx_out_d = 1'b1;
      endcase

      ready_d = (state_d == StIdle);
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StStop) && (baud_d == BaudLast) && (stop_d == StopLast);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_out_q <= 1'b1;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_out_q <= tx_out_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_ready   = ready_q;
   assign tx_out     = tx_out_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: scoreboard of sent words, checked by a sampling line receiver.
// Two instances cover STOP_BITS=1 and STOP_BITS=2 at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx_frame;

   localparam int unsigned Baud  = 1000000;
   localparam int unsigned ClkNs = 250;
   localparam int          Cpb   = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] tx_data = '0;
   logic       valid1 = 1'b0, valid2 = 1'b0;
   logic       rdy1, out1, busy1, done1;
   logic       rdy2, out2, busy2, done2;
   int         sel = 0;
   logic       line, rdy, bsy, dn;

   int         checks = 0;
   int         errors = 0;
   logic [6:0] exp_q[$];
   int         gap;

   assign line = (sel != 0) ? out2  : out1;
   assign rdy  = (sel != 0) ? rdy2  : rdy1;
   assign bsy  = (sel != 0) ? busy2 : busy1;
   assign dn   = (sel != 0) ? done2 : done1;

   always #(ClkNs / 2) clk = ~clk;

   uart_tx_frame #(.BAUD_RATE(Baud), .CLK_PERIOD_NS(ClkNs), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid1),
      .tx_ready(rdy1), .tx_out(out1), .busy(busy1), .frame_done(done1)
   );

   uart_tx_frame #(.BAUD_RATE(Baud), .CLK_PERIOD_NS(ClkNs), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid2),
      .tx_ready(rdy2), .tx_out(out2), .busy(busy2), .frame_done(done2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic even_par(input logic [6:0] d);
      int ones = 0;
      for (int i = 0; i < 7; i++) if (d[i]) ones++;
      return logic'(ones % 2);
   endfunction

   // Offer one word on the selected instance; tx_data switches to d_after right after accept.
   task automatic send(input int s, input logic [6:0] d, input logic [6:0] d_after);
      int n = 0;
      exp_q.push_back(d);
      tx_data = d;
      if (s != 0) valid2 = 1'b1; else valid1 = 1'b1;
      while (rdy !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      tx_data = d_after;
      valid1  = 1'b0;
      valid2  = 1'b0;
   endtask

   // Sample every cycle of one frame, then check the single IDLE cycle that follows it.
   task automatic rx_check(input int sb, output int gap_o);
      logic [63:0] smp;
      logic [6:0]  exp_d, got_d;
      logic        par;
      int          nb, busy_cnt, done_cnt, done_pos, broken;
      nb = 9 + sb;
      busy_cnt = 0; done_cnt = 0; done_pos = -1; broken = 0; gap_o = 0;
      smp = '0;
      exp_d = '0;
      if (exp_q.size() == 0) check("sb_empty", 0, 1);
      else exp_d = exp_q.pop_front();
      @(negedge clk);
      while (line !== 1'b0 && gap_o < 200) begin
         gap_o++;
         @(negedge clk);
      end
      if (gap_o >= 200) begin
         check("rx_timeout", 0, 1);
         return;
      end
      for (int i = 0; i < nb * Cpb; i++) begin
         if (i > 0) @(negedge clk);
         smp[i] = line;
         if (bsy === 1'b1) busy_cnt++;
         if (dn === 1'b1) begin
            done_cnt++;
            done_pos = i;
         end
      end
      for (int b = 0; b < nb; b++)
         for (int k = 1; k < Cpb; k++)
            if (smp[b*Cpb+k] !== smp[b*Cpb]) broken++;
      for (int j = 0; j < 7; j++) got_d[j] = smp[(j+1)*Cpb];
      par = smp[8*Cpb];
      if (smp[0] !== 1'b0) broken++;
      for (int s = 0; s < sb; s++) if (smp[(9+s)*Cpb] !== 1'b1) broken++;
      check("rx_data", 32'(got_d), 32'(exp_d));
      check("rx_parity", 32'(par), 32'(even_par(exp_d)));
      check("rx_broken", broken, 0);
      check("busy_cycles", busy_cnt, nb * Cpb);
      check("done_count", done_cnt, 1);
      check("done_pos", done_pos, nb * Cpb - 1);
      @(negedge clk);
      check("idle_line", 32'(line), 1);
      check("idle_ready", 32'(rdy), 1);
      check("idle_busy", 32'(bsy), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel   = 0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx_out", 32'(line), 1);
         check("rst_ready", 32'(rdy), 0);
         check("rst_busy", 32'(bsy), 0);
         check("rst_done", 32'(dn), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(rdy), 1);

      fork
         send(0, 7'h55, 7'h55);
         rx_check(1, gap);
      join

      fork
         send(0, 7'h07, 7'h07);
         rx_check(1, gap);
      join

      // Back-to-back with tx_valid held high across both frames.
      fork
         begin
            int n = 0;
            exp_q.push_back(7'h7F);
            exp_q.push_back(7'h00);
            tx_data = 7'h7F;
            valid1  = 1'b1;
            @(posedge clk);
            #1 tx_data = 7'h00;
            @(negedge clk);
            while (rdy !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            if (n >= 200) check("b2b_ready_timeout", 0, 1);
            @(posedge clk);
            #1 valid1 = 1'b0;
         end
         begin
            rx_check(1, gap);
            rx_check(1, gap);
            check("b2b_gap", gap, 0);
         end
      join

      // Reset in the middle of DATA bit 3 of an all-zero word.
      tx_data = 7'h00;
      valid1  = 1'b1;
      @(posedge clk);
      #1 valid1 = 1'b0;
      repeat (17) @(negedge clk);
      check("midrst_pre_line", 32'(line), 0);
      #10 rst_n = 1'b0;
      #1;
      check("midrst_tx_out", 32'(line), 1);
      check("midrst_busy", 32'(bsy), 0);
      check("midrst_ready", 32'(rdy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_after", 32'(rdy), 1);
      fork
         send(0, 7'h2A, 7'h2A);
         rx_check(1, gap);
      join

      // Two stop bits, tx_data flipped right after accept.
      sel = 1;
      @(negedge clk);
      fork
         send(1, 7'h1C, 7'h63);
         rx_check(2, gap);
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the stage directly upstream of the receiver block.
- Accepts a 7-bit parallel word through a valid/ready handshake.
- Serialises the word as one frame: start bit (0), 7 data bits LSB-first, even-parity bit, then STOP_BITS stop bits (1).
- Bit period is derived from the baud rate and the clock period, using the same formula as the receiver, so both ends agree on timing.

Parameters:
- BAUD_RATE, 9600, line rate in bits/s.
- CLK_PERIOD_NS, 60, clk period in ns.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- Derived localparam CLKS_PER_BIT = (1000000000/BAUD_RATE)/CLK_PERIOD_NS, integer division. Default value is 1736. Must be >= 2; elaborate-time error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  7  parallel word to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (async, rst_n low), regardless of state or mid-frame position:
  - tx_out=1, tx_ready=0, busy=0, frame_done=0.
  - State=IDLE; bit and baud counters cleared; shift register cleared.
  - First cycle after rst_n deasserts: tx_ready=1.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: accept occurs on the rising edge where tx_valid && tx_ready.
  - tx_ready=1 only in IDLE and never combinationally depends on tx_valid.
  - tx_data is captured into a 7-bit shift register.
  - Parity is computed at capture as the XOR of all 7 bits, so data plus parity always has an even count of ones.
  - tx_data changes after the accept do not affect the frame in flight.
- IDLE:
  - tx_out=1, busy=0.
  - On accept: go to START. tx_out=0 and busy=1 from the next cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Each bit is held on tx_out for exactly CLKS_PER_BIT cycles.
- START: tx_out=0 for one bit period, then DATA.
- DATA:
  - tx_out = shift-register bit 0; shift right at each bit-period end.
  - 3-bit bit counter 0..6; after bit 6 completes, go to PARITY.
- PARITY: tx_out = stored parity for one bit period, then STOP.
- STOP:
  - tx_out=1 for STOP_BITS bit periods.
  - frame_done pulses in the final cycle.
  - Then go to IDLE; busy drops that same edge.
- Frame length: accept edge to return to IDLE = (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - There is always at least one IDLE cycle (tx_ready=1) between frames.
  - If tx_valid is held high, the next START begins the cycle after that IDLE cycle.
  - The line therefore shows stop-bit high of at least STOP_BITS*CLKS_PER_BIT+1 cycles.
- tx_valid is ignored outside IDLE; no queuing.
- All outputs are registered; there are no glitches on tx_out.

Test Plan:
- Common setup: BAUD_RATE=1000000, CLK_PERIOD_NS=250, giving CLKS_PER_BIT=4.
- Reset: hold rst_n=0 for 3 cycles -> tx_out=1, tx_ready=0, busy=0 throughout; tx_ready=1 in the first cycle after release.
- Single frame, 7'h55: one valid pulse -> sampled mid-bit, tx_out = 0, 1,0,1,0,1,0,1, 0 (parity), 1 (stop). Each bit lasts 4 cycles; busy high for 40 cycles; frame_done pulses once at cycle 40.
- Odd-weight word, 7'h07: send -> data bits 1,1,1,0,0,0,0 and parity=1.
- Back-to-back: tx_valid held high with 7'h7F then 7'h00.
  - 7'h7F frame: parity 1.
  - 7'h00 frame: parity 0.
  - Exactly one IDLE cycle between frames, in which tx_ready=1 and tx_out=1.
  - Loopback into the receiver yields out=7'h7F then 7'h00 with broken=0.
- Mid-frame reset: assert rst_n=0 during DATA bit 3 -> tx_out=1 immediately, without waiting for clk; after release, a new 7'h2A frame is transmitted cleanly.
- STOP_BITS=2, input change after accept: tx_data changes in the cycle after accept -> transmitted bits match the captured word; stop high for 8 cycles; frame length 44 cycles.
